// File: rtl/ccff_programmer.sv
// ccff_programmer
//   Loads a configuration flip-flop chain of CHAIN_LEN bits from a valid/ready
//   word stream and repacks the bits falling out of the chain tail into
//   readback words.
//
//   The fabric prog_clk is produced outside this block by a glitch-free clock
//   gate enabled by ccff_shift_en. ccff_head and ccff_shift_en are driven
//   together right after an edge, so a bit driven after edge k is captured by
//   the chain at edge k+1.
//
// Ports
//   prog_clk       in   ungated programming clock
//   reset_n        in   asynchronous active-low reset
//   start          in   one-cycle pulse, begins a run (ignored while busy)
//   s_data/s_valid in   bitstream word stream
//   s_ready        out  a word is accepted in FETCH
//   ccff_head      out  serial bit to the chain head
//   ccff_tail      in   serial bit from the chain tail
//   ccff_shift_en  out  enable for the external prog_clk gate
//   m_data/m_valid out  readback words (no backpressure)
//   busy           out  run in progress
//   done           out  one-cycle pulse at the end of a run
//   bit_cnt        out  bits shifted in this run (saturates at CHAIN_LEN)
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | s_ready high, waiting for the next bitstream word; chain frozen
// SHIFT  | one chain shift per edge, LSB of the latched word first
// FINISH | one cycle: done pulse, partial readback word flushed
module ccff_programmer #(
  parameter int CHAIN_LEN = 80,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int RB_W  = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [RB_W-1:0]  RB_LAST  = RB_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FINISH} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] rb_buf_q, rb_buf_d;
  logic [RB_W-1:0]   rb_cnt_q, rb_cnt_d;
  logic              rb_pend_q, rb_pend_d;
  logic [WORD_W-1:0] rb_sample;

  logic              s_ready_d, head_d, shift_en_d, m_valid_d, busy_d, done_d;
  logic [WORD_W-1:0] m_data_d;
  logic [CNT_W-1:0]  bit_cnt_d;

  always_ff @(posedge prog_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      idx_q         <= '0;
      rb_buf_q      <= '0;
      rb_cnt_q      <= '0;
      rb_pend_q     <= 1'b0;
      s_ready       <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      m_data        <= '0;
      m_valid       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bit_cnt       <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      idx_q         <= idx_d;
      rb_buf_q      <= rb_buf_d;
      rb_cnt_q      <= rb_cnt_d;
      rb_pend_q     <= rb_pend_d;
      s_ready       <= s_ready_d;
      ccff_head     <= head_d;
      ccff_shift_en <= shift_en_d;
      m_data        <= m_data_d;
      m_valid       <= m_valid_d;
      busy          <= busy_d;
      done          <= done_d;
      bit_cnt       <= bit_cnt_d;
    end
  end

  // Pre-shift tail value merged into the readback buffer at its fill position.
  assign rb_sample = rb_buf_q | (WORD_W'(ccff_tail) << rb_cnt_q);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    rb_buf_d   = rb_buf_q;
    rb_cnt_d   = rb_cnt_q;
    rb_pend_d  = rb_pend_q;
    s_ready_d  = s_ready;
    head_d     = ccff_head;
    shift_en_d = ccff_shift_en;
    m_data_d   = m_data;
    m_valid_d  = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    bit_cnt_d  = bit_cnt;

    // A full readback word is strobed on the edge after its last sample.
    // Readback words line up with input words, so that edge never shifts.
    if (rb_pend_q) begin
      m_data_d  = rb_buf_q;
      m_valid_d = 1'b1;
      rb_buf_d  = '0;
      rb_cnt_d  = '0;
      rb_pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          busy_d    = 1'b1;
          s_ready_d = 1'b1;
          bit_cnt_d = '0;
          rb_buf_d  = '0;
          rb_cnt_d  = '0;
          rb_pend_d = 1'b0;
        end
      end

      FETCH: begin
        if (s_valid) begin
          state_d    = SHIFT;
          s_ready_d  = 1'b0;
          head_d     = s_data[0];
          shreg_d    = s_data >> 1;
          shift_en_d = 1'b1;
          idx_d      = '0;
        end
      end

      SHIFT: begin
        bit_cnt_d = bit_cnt + CNT_W'(1);
        rb_buf_d  = rb_sample;
        rb_cnt_d  = rb_cnt_q + RB_W'(1);
        if (rb_cnt_q == RB_LAST) begin
          rb_pend_d = 1'b1;
        end
        if (bit_cnt == LAST_CNT) begin
          state_d    = FINISH;
          shift_en_d = 1'b0;
          head_d     = 1'b0;
          done_d     = 1'b1;
          // Trailing partial word goes out now, together with done.
          if (rb_cnt_q != RB_LAST) begin
            m_data_d  = rb_sample;
            m_valid_d = 1'b1;
            rb_buf_d  = '0;
            rb_cnt_d  = '0;
          end
        end else if (idx_q == LAST_IDX) begin
          state_d    = FETCH;
          s_ready_d  = 1'b1;
          shift_en_d = 1'b0;
          head_d     = 1'b0;
        end else begin
          head_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ccff_programmer.sv
module tb_ccff_programmer;

  logic prog_clk = 1'b0;
  logic reset_n  = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // 20-bit chain instance
  logic       start20 = 1'b0, s_valid20 = 1'b0, s_ready20, head20, tail20, shift_en20;
  logic [7:0] s_data20 = '0, m_data20;
  logic       m_valid20, busy20, done20;
  logic [4:0] bit_cnt20;

  // 16-bit chain instance (exact multiple of the word width)
  logic       start16 = 1'b0, s_valid16 = 1'b0, s_ready16, head16, tail16, shift_en16;
  logic [7:0] s_data16 = '0, m_data16;
  logic       m_valid16, busy16, done16;
  logic [4:0] bit_cnt16;

  ccff_programmer #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
    .prog_clk(prog_clk), .reset_n(reset_n), .start(start20),
    .s_data(s_data20), .s_valid(s_valid20), .s_ready(s_ready20),
    .ccff_head(head20), .ccff_tail(tail20), .ccff_shift_en(shift_en20),
    .m_data(m_data20), .m_valid(m_valid20), .busy(busy20), .done(done20),
    .bit_cnt(bit_cnt20));

  ccff_programmer #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(prog_clk), .reset_n(reset_n), .start(start16),
    .s_data(s_data16), .s_valid(s_valid16), .s_ready(s_ready16),
    .ccff_head(head16), .ccff_tail(tail16), .ccff_shift_en(shift_en16),
    .m_data(m_data16), .m_valid(m_valid16), .busy(busy16), .done(done16),
    .bit_cnt(bit_cnt16));

  // Fabric chain models: shift on every gated edge, tail is the far end.
  logic        preload = 1'b0;
  logic [19:0] chain20 = '0;
  logic [15:0] chain16 = '0;
  assign tail20 = chain20[19];
  assign tail16 = chain16[15];

  always @(posedge prog_clk) begin
    if (preload) chain20 <= '1;
    else if (shift_en20) chain20 <= {chain20[18:0], head20};
    if (preload) chain16 <= '1;
    else if (shift_en16) chain16 <= {chain16[14:0], head16};
  end

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Observer for the 20-bit instance, sampled on the falling edge.
  logic        mon_clr = 1'b0;
  int          n_shift, n_rb, hs, done_cyc;
  logic [19:0] cap_bits;
  logic [23:0] rb_log;

  always @(negedge prog_clk) begin
    if (mon_clr) begin
      n_shift = 0; n_rb = 0; hs = -1; done_cyc = -1;
      cap_bits = '0; rb_log = '0;
    end else begin
      if (hs < 0 && s_valid20 && s_ready20) hs = cyc + 1;
      if (shift_en20) begin
        if (n_shift < 20) cap_bits[n_shift] = head20;
        n_shift++;
      end
      if (m_valid20) begin
        if (n_rb < 3) rb_log[n_rb*8 +: 8] = m_data20;
        n_rb++;
      end
      if (done20 && done_cyc < 0) done_cyc = cyc - hs + 2;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic wait_ready(input logic val, input string nm);
    int k = 0;
    while (s_ready20 !== val && k < 50) begin
      tick();
      k++;
    end
    if (s_ready20 !== val) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout waiting for s_ready=%0b", nm, val);
    end
  endtask

  typedef struct {
    string       name;
    logic [23:0] words;     // word0 in [7:0]
    bit          preload;
    bit          stall;     // drop s_valid 5 cycles before word 1
    bit          glitch;    // pulse start mid-SHIFT
    logic [19:0] exp_bits;  // bit i = i-th bit sent
    logic [23:0] exp_rb;    // readback word0 in [7:0]
    int          exp_done;  // cycle of done, handshake cycle = 1
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int          k;
    logic [19:0] exp_chain;
    mon_clr = 1'b1; preload = v.preload;
    start20 = 1'b1; s_valid20 = 1'b1; s_data20 = v.words[7:0];
    tick();
    start20 = 1'b0; preload = 1'b0; mon_clr = 1'b0;
    chk({v.name, "_busy_rise"}, 32'(busy20), 32'd1);
    chk({v.name, "_ready_rise"}, 32'(s_ready20), 32'd1);
    wait_ready(1'b0, {v.name, "_w0"});
    if (v.stall) s_valid20 = 1'b0;
    else s_data20 = v.words[15:8];
    if (v.glitch) begin
      repeat (3) tick();
      start20 = 1'b1;
      tick();
      start20 = 1'b0;
      chk({v.name, "_glitch_bit_cnt"}, 32'(bit_cnt20), 32'd4);
      chk({v.name, "_glitch_busy"}, 32'(busy20), 32'd1);
    end
    wait_ready(1'b1, {v.name, "_f1"});
    if (v.stall) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        chk({v.name, "_stall_shift_en"}, 32'(shift_en20), 32'd0);
      end
      s_valid20 = 1'b1;
      s_data20 = v.words[15:8];
    end
    wait_ready(1'b0, {v.name, "_w1"});
    s_data20 = v.words[23:16];
    k = 0;
    while (done20 !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk({v.name, "_done_seen"}, 32'(done20), 32'd1);
    s_valid20 = 1'b0;
    tick();
    chk({v.name, "_busy_fall"}, 32'(busy20), 32'd0);
    chk({v.name, "_done_pulse"}, 32'(done20), 32'd0);
    repeat (3) tick();
    chk({v.name, "_bit_cnt_hold"}, 32'(bit_cnt20), 32'd20);
    chk({v.name, "_shift_edges"}, 32'(n_shift), 32'd20);
    chk({v.name, "_bits_sent"}, 32'(cap_bits), 32'(v.exp_bits));
    for (int i = 0; i < 20; i++) exp_chain[19-i] = v.exp_bits[i];
    chk({v.name, "_chain"}, 32'(chain20), 32'(exp_chain));
    chk({v.name, "_rb_count"}, 32'(n_rb), 32'd3);
    chk({v.name, "_rb_words"}, 32'(rb_log), 32'(v.exp_rb));
    chk({v.name, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n16, nrb16, dcyc, hs16;
    logic [15:0] rb16;

    vecs[0] = '{"basic",   24'hF93CA5, 1'b1, 1'b0, 1'b0, 20'h93CA5, 24'h0FFFFF, 24};
    vecs[1] = '{"stall",   24'hF93CA5, 1'b1, 1'b1, 1'b0, 20'h93CA5, 24'h0FFFFF, 29};
    vecs[2] = '{"glitch",  24'hF93CA5, 1'b1, 1'b0, 1'b1, 20'h93CA5, 24'h0FFFFF, 24};
    vecs[3] = '{"reprog1", 24'h06C35A, 1'b1, 1'b0, 1'b0, 20'h6C35A, 24'h0FFFFF, 24};
    vecs[4] = '{"reprog2", 24'h06C35A, 1'b0, 1'b0, 1'b0, 20'h6C35A, 24'h06C35A, 24};

    repeat (2) @(posedge prog_clk);
    #1;
    chk("rst_busy", 32'(busy20), 32'd0);
    chk("rst_s_ready", 32'(s_ready20), 32'd0);
    chk("rst_shift_en", 32'(shift_en20), 32'd0);
    chk("rst_head", 32'(head20), 32'd0);
    chk("rst_done", 32'(done20), 32'd0);
    chk("rst_m_valid", 32'(m_valid20), 32'd0);
    chk("rst_m_data", 32'(m_data20), 32'd0);
    chk("rst_bit_cnt", 32'(bit_cnt20), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_s_ready", 32'(s_ready20), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset after 11 shifts, then a normal load.
    preload = 1'b1; start20 = 1'b1; s_valid20 = 1'b1; s_data20 = 8'hA5;
    tick();
    preload = 1'b0; start20 = 1'b0;
    wait_ready(1'b0, "rst_w0");
    s_data20 = 8'h3C;
    wait_ready(1'b1, "rst_f1");
    wait_ready(1'b0, "rst_w1");
    repeat (3) tick();
    chk("rst_mid_bit_cnt", 32'(bit_cnt20), 32'd11);
    chk("rst_mid_shift_en_pre", 32'(shift_en20), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_shift_en", 32'(shift_en20), 32'd0);
    chk("rst_mid_busy", 32'(busy20), 32'd0);
    chk("rst_mid_s_ready", 32'(s_ready20), 32'd0);
    chk("rst_mid_head", 32'(head20), 32'd0);
    chk("rst_mid_bit_cnt0", 32'(bit_cnt20), 32'd0);
    tick();
    reset_n = 1'b1;
    s_valid20 = 1'b0;
    tick();
    vecs[0].name = "after_rst";
    run_vec(vecs[0]);

    // Exact multiple: 16-bit chain, words 0x01 then 0x80.
    preload = 1'b1; start16 = 1'b1; s_valid16 = 1'b1; s_data16 = 8'h01;
    tick();
    preload = 1'b0; start16 = 1'b0;
    chk("x16_busy_rise", 32'(busy16), 32'd1);
    chk("x16_ready_rise", 32'(s_ready16), 32'd1);
    hs16 = cyc + 1;
    tick();
    s_data16 = 8'h80;
    n16 = 0; nrb16 = 0; dcyc = -1; rb16 = '0;
    for (int k = 0; k < 40; k++) begin
      if (shift_en16) n16++;
      if (m_valid16) begin
        if (nrb16 < 2) rb16[nrb16*8 +: 8] = m_data16;
        nrb16++;
      end
      if (done16 && dcyc < 0) dcyc = cyc - hs16 + 2;
      tick();
    end
    s_valid16 = 1'b0;
    chk("x16_shift_edges", 32'(n16), 32'd16);
    chk("x16_rb_count", 32'(nrb16), 32'd2);
    chk("x16_rb_words", 32'(rb16), 32'h0000FFFF);
    chk("x16_done_cycle", 32'(dcyc), 32'd19);
    chk("x16_bit_cnt_hold", 32'(bit_cnt16), 32'd16);
    chk("x16_chain", 32'(chain16), 32'h00008001);
    chk("x16_busy_fall", 32'(busy16), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
